// File: rtl/hangman_display_engine.sv
// hangman_display_engine: owns the Hangman round state (stored word, revealed
// mask, miss buffer, miss counter, round FSM), flags duplicate guesses and
// drives two registered ASCII LCD row buffers (MSB byte = column 0).
// Optional build macro: LIVES_DISPLAY_EN (remaining-lives digit in the last
// bottom column while playing; requires MAX_MISS <= 9).
module hangman_display_engine #(
   parameter int WORD_LEN = 5,
   parameter int MAX_MISS = 6,
   parameter int COLS     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            new_game,
   input  logic [8*WORD_LEN-1:0]           word,
   input  logic                            guess_valid,
   input  logic [7:0]                      guess,
   output logic [8*COLS-1:0]               top,
   output logic [8*COLS-1:0]               bottom,
   output logic [1:0]                      state,
   output logic [$clog2(MAX_MISS+1)-1:0]   miss_count,
   output logic                            dup_guess
);

   localparam int MW       = $clog2(MAX_MISS + 1);
   localparam int WORD_OFF = (COLS - WORD_LEN) / 2;
   localparam int WIN_OFF  = (COLS - 3) / 2;
   localparam int LOSE_OFF = (COLS - 4) / 2;
`ifdef LIVES_DISPLAY_EN
   // Miss field is centred in the columns left of the lives digit.
   localparam int MISS_OFF = (COLS - 1 - MAX_MISS) / 2;
`else
   localparam int MISS_OFF = (COLS - MAX_MISS) / 2;
`endif
   localparam logic [23:0] WIN_TXT  = "WIN";
   localparam logic [31:0] LOSE_TXT = "LOSE";

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_WIN  = 2'b10,
      S_LOSE = 2'b11
   } state_t;

   state_t              state_reg, state_next;
   logic [7:0]          word_reg     [WORD_LEN];
   logic [7:0]          word_next    [WORD_LEN];
   logic [7:0]          miss_buf_reg [MAX_MISS];
   logic [7:0]          miss_buf_next[MAX_MISS];
   logic [WORD_LEN-1:0] mask_reg, mask_next;
   logic [MW-1:0]       miss_count_reg, miss_count_next;
   logic                dup_reg, dup_next;
   logic [8*COLS-1:0]   top_reg, bottom_reg;
   logic [8*COLS-1:0]   top_packed, bottom_packed;
   logic [7:0]          top_cols    [COLS];
   logic [7:0]          bottom_cols [COLS];

   logic [WORD_LEN-1:0] match;
   logic [WORD_LEN-1:0] rev_hit;
   logic [MAX_MISS-1:0] buf_hit;
   logic                is_dup;

   // Per-letter and per-miss-slot comparators against the incoming guess.
   genvar gi;
   generate
      for (gi = 0; gi < WORD_LEN; gi++) begin : g_match
         assign match[gi]   = (word_reg[gi] == guess);
         assign rev_hit[gi] = mask_reg[gi] & match[gi];
      end
      for (gi = 0; gi < MAX_MISS; gi++) begin : g_buf
         assign buf_hit[gi] = (miss_buf_reg[gi] == guess);
      end
      for (gi = 0; gi < COLS; gi++) begin : g_pack
         assign top_packed[8*(COLS-1-gi) +: 8]    = top_cols[gi];
         assign bottom_packed[8*(COLS-1-gi) +: 8] = bottom_cols[gi];
      end
   endgenerate

   assign is_dup = (|rev_hit) | (|buf_hit);

   // Round update: new_game has priority; guesses only count while playing.
   always_comb begin
      state_next      = state_reg;
      word_next       = word_reg;
      mask_next       = mask_reg;
      miss_buf_next   = miss_buf_reg;
      miss_count_next = miss_count_reg;
      dup_next        = 1'b0;
      if (new_game) begin
         for (int i = 0; i < WORD_LEN; i++)
            word_next[i] = word[8*(WORD_LEN-1-i) +: 8];
         for (int j = 0; j < MAX_MISS; j++)
            miss_buf_next[j] = 8'h5F;
         mask_next       = '0;
         miss_count_next = '0;
         state_next      = S_PLAY;
      end else if (guess_valid && state_reg == S_PLAY) begin
         if (is_dup) begin
            dup_next = 1'b1;
         end else if (|match) begin
            mask_next = mask_reg | match;
            if (&mask_next)
               state_next = S_WIN;
         end else begin
            for (int j = 0; j < MAX_MISS; j++)
               if (MW'(j) == miss_count_reg)
                  miss_buf_next[j] = guess;
            miss_count_next = miss_count_reg + 1'b1;
            if (miss_count_next == MW'(MAX_MISS))
               state_next = S_LOSE;
         end
      end
   end

   // Row images built from next-state values so they change with state.
   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         top_cols[c]    = 8'h20;
         bottom_cols[c] = 8'h20;
      end
      case (state_next)
         S_PLAY: begin
            for (int i = 0; i < WORD_LEN; i++)
               top_cols[WORD_OFF+i] = mask_next[i] ? word_next[i] : 8'h5F;
            for (int j = 0; j < MAX_MISS; j++)
               bottom_cols[MISS_OFF+j] = miss_buf_next[j];
`ifdef LIVES_DISPLAY_EN
            bottom_cols[COLS-1] = 8'h30 + 8'(MAX_MISS) - 8'(miss_count_next);
`endif
         end
         S_WIN: begin
            for (int k = 0; k < 3; k++)
               top_cols[WIN_OFF+k] = WIN_TXT[8*(2-k) +: 8];
            for (int i = 0; i < WORD_LEN; i++)
               bottom_cols[WORD_OFF+i] = word_next[i];
         end
         S_LOSE: begin
            for (int k = 0; k < 4; k++)
               top_cols[LOSE_OFF+k] = LOSE_TXT[8*(3-k) +: 8];
            for (int i = 0; i < WORD_LEN; i++)
               bottom_cols[WORD_OFF+i] = word_next[i];
         end
         default: ;
      endcase
   end

   // State and display registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         mask_reg       <= '0;
         miss_count_reg <= '0;
         dup_reg        <= 1'b0;
         top_reg        <= {COLS{8'h20}};
         bottom_reg     <= {COLS{8'h20}};
         for (int i = 0; i < WORD_LEN; i++) word_reg[i]     <= 8'h20;
         for (int j = 0; j < MAX_MISS; j++) miss_buf_reg[j] <= 8'h5F;
      end else begin
         state_reg      <= state_next;
         mask_reg       <= mask_next;
         miss_count_reg <= miss_count_next;
         dup_reg        <= dup_next;
         top_reg        <= top_packed;
         bottom_reg     <= bottom_packed;
         word_reg       <= word_next;
         miss_buf_reg   <= miss_buf_next;
      end
   end

   assign top        = top_reg;
   assign bottom     = bottom_reg;
   assign state      = state_reg;
   assign miss_count = miss_count_reg;
   assign dup_guess  = dup_reg;

endmodule

// File: tb/tb_hangman_display_engine.sv
// Self-checking bench for hangman_display_engine with a string-level model.
module tb_hangman_display_engine;

   localparam int WL = 5;
   localparam int MM = 6;
   localparam int CL = 16;
   localparam int MW = $clog2(MM + 1);
   localparam int TW = 16*CL + 2 + MW + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            new_game = 1'b0;
   logic [8*WL-1:0] word = '0;
   logic            guess_valid = 1'b0;
   logic [7:0]      guess = 8'h00;
   logic [8*CL-1:0] top, bottom;
   logic [1:0]      state;
   logic [MW-1:0]   miss_count;
   logic            dup_guess;

   int total = 0;
   int bad   = 0;

   hangman_display_engine #(.WORD_LEN(WL), .MAX_MISS(MM), .COLS(CL)) dut (
      .clk(clk), .rst(rst), .new_game(new_game), .word(word),
      .guess_valid(guess_valid), .guess(guess), .top(top), .bottom(bottom),
      .state(state), .miss_count(miss_count), .dup_guess(dup_guess)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   byte m_word[WL];
   bit  m_rev[WL];
   byte m_miss[$];
   int  m_state;   // 0 idle, 1 play, 2 win, 3 lose
   bit  m_dup;

   function automatic void model_reset();
      for (int i = 0; i < WL; i++) begin m_word[i] = " "; m_rev[i] = 0; end
      m_miss.delete();
      m_state = 0;
      m_dup   = 0;
   endfunction

   function automatic void model_step(bit ng, logic [8*WL-1:0] w, bit gv, byte g);
      bit dup, hit, all;
      m_dup = 0;
      if (ng) begin
         for (int i = 0; i < WL; i++) begin m_word[i] = w[8*(WL-1-i) +: 8]; m_rev[i] = 0; end
         m_miss.delete();
         m_state = 1;
      end else if (gv && m_state == 1) begin
         dup = 0; hit = 0;
         for (int i = 0; i < WL; i++) if (m_rev[i] && m_word[i] == g) dup = 1;
         foreach (m_miss[k]) if (m_miss[k] == g) dup = 1;
         if (dup) m_dup = 1;
         else begin
            for (int i = 0; i < WL; i++) if (m_word[i] == g) begin m_rev[i] = 1; hit = 1; end
            if (hit) begin
               all = 1;
               for (int i = 0; i < WL; i++) if (!m_rev[i]) all = 0;
               if (all) m_state = 2;
            end else begin
               m_miss.push_back(g);
               if (m_miss.size() == MM) m_state = 3;
            end
         end
      end
   endfunction

   function automatic string center(string s, int width);
      string r = "";
      for (int k = 0; k < (width - s.len()) / 2; k++) r = {r, " "};
      r = {r, s};
      while (r.len() < width) r = {r, " "};
      return r;
   endfunction

   function automatic logic [8*CL-1:0] to_row(string r);
      logic [8*CL-1:0] v;
      for (int c = 0; c < CL; c++) v[8*(CL-1-c) +: 8] = r[c];
      return v;
   endfunction

   function automatic logic [TW-1:0] exp_all();
      string t, b, ws;
      ws = "";
      for (int i = 0; i < WL; i++) ws = $sformatf("%s%c", ws, m_word[i]);
      t = center("", CL);
      b = center("", CL);
      if (m_state == 1) begin
         t = "";
         for (int i = 0; i < WL; i++) t = $sformatf("%s%c", t, m_rev[i] ? m_word[i] : 8'h5F);
         t = center(t, CL);
         b = "";
         foreach (m_miss[k]) b = $sformatf("%s%c", b, m_miss[k]);
         while (b.len() < MM) b = {b, "_"};
`ifdef LIVES_DISPLAY_EN
         b = $sformatf("%s%0d", center(b, CL - 1), MM - m_miss.size());
`else
         b = center(b, CL);
`endif
      end else if (m_state == 2) begin
         t = center("WIN", CL);  b = center(ws, CL);
      end else if (m_state == 3) begin
         t = center("LOSE", CL); b = center(ws, CL);
      end
      return {to_row(t), to_row(b), 2'(m_state), MW'(m_miss.size()), m_dup};
   endfunction

   // Drive one clock worth of inputs; strobes drop 1 time unit after the edge.
   task automatic step(bit ng, logic [8*WL-1:0] w, bit gv, byte g);
      @(negedge clk);
      new_game = ng; word = w; guess_valid = gv; guess = g;
      @(posedge clk);
      #1;
      new_game = 0; guess_valid = 0;
      model_step(ng, w, gv, g);
      $display("step ng=%0d gv=%0d g=%c state=%0d miss=%0d dup=%0d", ng, gv, g, state, miss_count, dup_guess);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1;
      #12;
      model_reset();
      total++;
      if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
         bad++; $display("FAIL reset got=%h exp=%h", {top, bottom, state, miss_count, dup_guess}, exp_all());
      end
      @(negedge clk); rst = 0;
      step(0, "HELLO", 1, "H");   // guess in IDLE is ignored
      total++;
      if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
         bad++; $display("FAIL idle_guess got=%h exp=%h", {top, bottom, state, miss_count, dup_guess}, exp_all());
      end
   endtask

   task automatic test_hit_dup();
      byte g[4] = '{8'h00, "L", "L", 8'h00};
      bit  v[4] = '{0, 1, 1, 0};
      for (int s = 0; s < 4; s++) begin
         step(s == 0, "HELLO", v[s], g[s]);
         total++;
         if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
            bad++; $display("FAIL hit_dup[%0d] got=%h exp=%h", s, {top, bottom, state, miss_count, dup_guess}, exp_all());
         end
      end
      total++;
      if (top !== to_row("     __LL_      ")) begin
         bad++; $display("FAIL hit_literal got=%h exp=%h", top, to_row("     __LL_      "));
      end
   endtask

   task automatic test_miss_dup();
      byte g[4] = '{8'h00, "Z", "Q", "Z"};
      for (int s = 0; s < 4; s++) begin
         step(s == 0, "HELLO", s != 0, g[s]);
         total++;
         if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
            bad++; $display("FAIL miss_dup[%0d] got=%h exp=%h", s, {top, bottom, state, miss_count, dup_guess}, exp_all());
         end
      end
      total++;
      if (miss_count !== 2 || dup_guess !== 1'b1) begin
         bad++; $display("FAIL miss_dup_cnt got=%0d/%0d exp=2/1", miss_count, dup_guess);
      end
   endtask

   task automatic test_win();
      byte g[6] = '{"H", "E", "L", "O", "A", "Z"};
      for (int s = 0; s < 6; s++) begin
         step(0, "HELLO", 1, g[s]);
         total++;
         if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
            bad++; $display("FAIL win[%0d] got=%h exp=%h", s, {top, bottom, state, miss_count, dup_guess}, exp_all());
         end
      end
      total++;
      if (state !== 2'b10 || top !== to_row("      WIN       ") || bottom !== to_row("     HELLO      ")) begin
         bad++; $display("FAIL win_literal got=%0d %h exp=2 %h", state, top, to_row("      WIN       "));
      end
   endtask

   task automatic test_lose();
      byte g[7] = '{8'h00, "A", "B", "C", "D", "F", "G"};
      for (int s = 0; s < 7; s++) begin
         step(s == 0, "HELLO", s != 0, g[s]);
         total++;
         if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
            bad++; $display("FAIL lose[%0d] got=%h exp=%h", s, {top, bottom, state, miss_count, dup_guess}, exp_all());
         end
      end
      total++;
      if (state !== 2'b11 || miss_count !== 6 || top !== to_row("      LOSE      ")) begin
         bad++; $display("FAIL lose_literal got=%0d %0d exp=3 6", state, miss_count);
      end
      step(1, "WORLD", 1, "Q");   // new_game wins, guess dropped
      total++;
      if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
         bad++; $display("FAIL ng_priority got=%h exp=%h", {top, bottom, state, miss_count, dup_guess}, exp_all());
      end
   endtask

   task automatic test_async_reset();
      step(1, "HELLO", 0, 8'h00);
      step(0, "HELLO", 1, "X");
      step(0, "HELLO", 1, "Y");
      total++;
      if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
         bad++; $display("FAIL pre_rst got=%h exp=%h", {top, bottom, state, miss_count, dup_guess}, exp_all());
      end
      @(negedge clk); #2;
      rst = 1;
      #1;
      model_reset();
      total++;
      if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
         bad++; $display("FAIL async_rst got=%h exp=%h", {top, bottom, state, miss_count, dup_guess}, exp_all());
      end
      @(negedge clk); rst = 0;
   endtask

   task automatic test_random();
      logic [8*WL-1:0] w;
      bit ng, gv;
      byte g;
      w = "ABCDE";
      for (int s = 0; s < 400; s++) begin
         if (s == 0 || $urandom_range(0, 19) == 0) begin
            for (int i = 0; i < WL; i++) w[8*i +: 8] = 8'(8'h41 + $urandom_range(0, 7));
            ng = 1;
         end else ng = 0;
         gv = ($urandom_range(0, 3) != 0);
         g  = 8'(8'h41 + $urandom_range(0, 11));
         step(ng, w, gv, g);
         total++;
         if ({top, bottom, state, miss_count, dup_guess} !== exp_all()) begin
            bad++; $display("FAIL rand[%0d] got=%h exp=%h", s, {top, bottom, state, miss_count, dup_guess}, exp_all());
         end
      end
   endtask

   initial begin
      test_reset();
      test_hit_dup();
      test_miss_dup();
      test_win();
      test_lose();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
